// File: rtl/cfg_target_model.sv
// Behavioural model of a configuration-space target: NUM_DEV word memories behind a
// held-request / done-pulse handshake with a fixed per-beat latency and optional byte expansion.
module cfg_target_model #(
    parameter int NUM_DEV = 2,
    parameter int DEPTH   = 256,
    parameter int LAT     = 2,
    parameter int ADDR_W  = 14
) (
    input  logic              clock_afu,
    input  logic              reset_afu,
    input  logic [1:0]        cfg_tgt_devsel,
    input  logic [ADDR_W-1:0] cfg_tgt_addr,
    input  logic              cfg_tgt_wren,
    input  logic [31:0]       cfg_tgt_wdata,
    input  logic              cfg_tgt_rden,
    input  logic              cfg_tgt_expand_enable,
    input  logic              cfg_tgt_expand_dir,
    output logic [31:0]       tgt_cfg_rdata,
    output logic              tgt_cfg_done,
    output logic [1:0]        tgt_cfg_bresp,
    output logic [1:0]        tgt_cfg_rresp,
    output logic [7:0]        tgt_cfg_status,
    output logic              tgt_err_unimplemented_addr
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned MEM_N  = NUM_DEV * DEPTH;
    localparam int unsigned IDX_W  = $clog2(MEM_N);
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LAT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        WAIT_DROP
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       beat_q;
    logic [1:0]       dev_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic             is_wr_q, is_rd_q, exp_q, dir_q;
    logic [1:0]       resp_q;
    logic             addr_err_q;
    logic [31:0]      rbuf_q;

    logic [31:0] mem [MEM_N];

    logic             req, conflict, dev_bad, addr_bad;
    logic [1:0]       req_resp;
    logic             req_addr_err;
    logic             beat_end, last_beat, acc_ok;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_rd;
    logic [31:0]      rbuf_d;
    logic [3:0]       be;

    // Classify the request as seen in IDLE; simultaneous read+write wins over address decode.
    always_comb begin
        req          = cfg_tgt_wren | cfg_tgt_rden;
        conflict     = cfg_tgt_wren & cfg_tgt_rden;
        dev_bad      = 32'(cfg_tgt_devsel) >= 32'(NUM_DEV);
        addr_bad     = 32'(cfg_tgt_addr) >= 32'(DEPTH);
        req_resp     = RESP_OKAY;
        req_addr_err = 1'b0;
        if (conflict) begin
            req_resp = RESP_SLVERR;
        end else if (dev_bad) begin
            req_resp = RESP_DECERR;
        end else if (addr_bad) begin
            req_resp     = RESP_SLVERR;
            req_addr_err = 1'b1;
        end
    end

    // Beat bookkeeping: lane order reverses when dir is set.
    always_comb begin
        beat_end  = (state_q == BUSY) && (cnt_q == '0);
        last_beat = !exp_q || (beat_q == 2'd3);
        acc_ok    = (resp_q == RESP_OKAY);
        lane      = beat_q ^ {2{dir_q}};
        idx       = acc_ok ? IDX_W'({dev_q, addr_q}) : '0;
    end

    assign mem_rd = mem[idx];

    // Read assembly and write byte enables for the beat that is ending.
    always_comb begin
        rbuf_d = rbuf_q;
        be     = '0;
        if (!exp_q) begin
            rbuf_d = mem_rd;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane == 2'(i)) begin
                    rbuf_d[8*i +: 8] = mem_rd[8*i +: 8];
                end
            end
        end
        if (beat_end && is_wr_q && acc_ok) begin
            be = exp_q ? (4'b0001 << lane) : 4'hF;
        end
    end

    // Storage is deliberately not reset; already-committed beats survive an abort.
    always_ff @(posedge clock_afu) begin
        if (be[0]) mem[idx][7:0]   <= wdata_q[7:0];
        if (be[1]) mem[idx][15:8]  <= wdata_q[15:8];
        if (be[2]) mem[idx][23:16] <= wdata_q[23:16];
        if (be[3]) mem[idx][31:24] <= wdata_q[31:24];
    end

    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req) state_d = BUSY;
            BUSY:      if (beat_end && last_beat) state_d = DONE;
            DONE:      state_d = WAIT_DROP;
            WAIT_DROP: if (!cfg_tgt_wren && !cfg_tgt_rden) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Request capture, beat sequencing and registered completion outputs.
    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu) begin
            cnt_q                      <= '0;
            beat_q                     <= '0;
            dev_q                      <= '0;
            addr_q                     <= '0;
            wdata_q                    <= '0;
            is_wr_q                    <= 1'b0;
            is_rd_q                    <= 1'b0;
            exp_q                      <= 1'b0;
            dir_q                      <= 1'b0;
            resp_q                     <= RESP_OKAY;
            addr_err_q                 <= 1'b0;
            rbuf_q                     <= '0;
            tgt_cfg_rdata              <= '0;
            tgt_cfg_done               <= 1'b0;
            tgt_cfg_bresp              <= RESP_OKAY;
            tgt_cfg_rresp              <= RESP_OKAY;
            tgt_cfg_status             <= '0;
            tgt_err_unimplemented_addr <= 1'b0;
        end else begin
            tgt_cfg_rdata              <= '0;
            tgt_cfg_done               <= 1'b0;
            tgt_cfg_bresp              <= RESP_OKAY;
            tgt_cfg_rresp              <= RESP_OKAY;
            tgt_err_unimplemented_addr <= 1'b0;

            if (state_q == IDLE && req) begin
                cnt_q      <= CNT_RELOAD;
                beat_q     <= '0;
                dev_q      <= cfg_tgt_devsel;
                addr_q     <= cfg_tgt_addr[AW-1:0];
                wdata_q    <= cfg_tgt_wdata;
                is_wr_q    <= cfg_tgt_wren;
                is_rd_q    <= cfg_tgt_rden;
                exp_q      <= cfg_tgt_expand_enable;
                dir_q      <= cfg_tgt_expand_dir;
                resp_q     <= req_resp;
                addr_err_q <= req_addr_err;
                rbuf_q     <= '0;
            end

            if (state_q == BUSY) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    rbuf_q <= rbuf_d;
                    if (!last_beat) begin
                        beat_q <= beat_q + 2'd1;
                        cnt_q  <= CNT_RELOAD;
                    end
                end
            end

            if (beat_end && last_beat) begin
                tgt_cfg_done               <= 1'b1;
                tgt_cfg_status             <= tgt_cfg_status + 8'd1;
                tgt_err_unimplemented_addr <= addr_err_q;
                tgt_cfg_rdata              <= (is_rd_q && acc_ok) ? rbuf_d : '0;
                tgt_cfg_bresp              <= is_wr_q ? resp_q : RESP_OKAY;
                tgt_cfg_rresp              <= is_rd_q ? resp_q : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_cfg_target_model.sv
// Randomized scoreboard bench for cfg_target_model: a word-array reference model predicts
// each completion (cycle, data, responses, status); a monitor checks every done pulse.
module tb_cfg_target_model;

    localparam int NUM_DEV = 2;
    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int ADDR_W  = 14;

    logic              clock_afu = 1'b0;
    logic              reset_afu;
    logic [1:0]        cfg_tgt_devsel;
    logic [ADDR_W-1:0] cfg_tgt_addr;
    logic              cfg_tgt_wren;
    logic [31:0]       cfg_tgt_wdata;
    logic              cfg_tgt_rden;
    logic              cfg_tgt_expand_enable;
    logic              cfg_tgt_expand_dir;
    logic [31:0]       tgt_cfg_rdata;
    logic              tgt_cfg_done;
    logic [1:0]        tgt_cfg_bresp;
    logic [1:0]        tgt_cfg_rresp;
    logic [7:0]        tgt_cfg_status;
    logic              tgt_err_unimplemented_addr;

    cfg_target_model #(
        .NUM_DEV(NUM_DEV),
        .DEPTH  (DEPTH),
        .LAT    (LAT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock_afu                 (clock_afu),
        .reset_afu                 (reset_afu),
        .cfg_tgt_devsel            (cfg_tgt_devsel),
        .cfg_tgt_addr              (cfg_tgt_addr),
        .cfg_tgt_wren              (cfg_tgt_wren),
        .cfg_tgt_wdata             (cfg_tgt_wdata),
        .cfg_tgt_rden              (cfg_tgt_rden),
        .cfg_tgt_expand_enable     (cfg_tgt_expand_enable),
        .cfg_tgt_expand_dir        (cfg_tgt_expand_dir),
        .tgt_cfg_rdata             (tgt_cfg_rdata),
        .tgt_cfg_done              (tgt_cfg_done),
        .tgt_cfg_bresp             (tgt_cfg_bresp),
        .tgt_cfg_rresp             (tgt_cfg_rresp),
        .tgt_cfg_status            (tgt_cfg_status),
        .tgt_err_unimplemented_addr(tgt_err_unimplemented_addr)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic        err;
        logic [7:0]  status;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl [NUM_DEV][DEPTH];
    logic [7:0]  model_status = 8'd0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned done_cnt = 0;

    logic [1:0]        r_dev;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr, r_rd;
    int unsigned       r_op;
    int unsigned       start;

    always #5 clock_afu = ~clock_afu;

    always @(posedge clock_afu) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour: one expected completion per accepted request.
    task automatic push_exp(input logic [1:0] dev, input logic [ADDR_W-1:0] addr,
                            input logic wr, input logic rd, input logic ex,
                            input logic [31:0] wdata, input int unsigned issue);
        exp_t e;
        logic [1:0] code;
        e.cyc   = issue + (ex ? 4 * LAT + 1 : LAT + 1);
        e.rdata = '0;
        e.bresp = 2'b00;
        e.rresp = 2'b00;
        e.err   = 1'b0;
        if (wr && rd) begin
            e.bresp = 2'b10;
            e.rresp = 2'b10;
        end else begin
            if (int'(dev) >= NUM_DEV)     code = 2'b11;
            else if (int'(addr) >= DEPTH) code = 2'b10;
            else                          code = 2'b00;
            e.err = (code == 2'b10);
            if (wr) e.bresp = code;
            else    e.rresp = code;
            if (code == 2'b00) begin
                if (wr) mdl[dev[0]][addr[7:0]] = wdata;
                else    e.rdata = mdl[dev[0]][addr[7:0]];
            end
        end
        model_status = model_status + 8'd1;
        e.status     = model_status;
        sb.push_back(e);
    endtask

    // Waits for the next done while scrambling the non-handshake inputs.
    task automatic wait_done(input int unsigned from);
        int unsigned n = 0;
        while (done_cnt == from && n < 100) begin
            @(negedge clock_afu);
            cfg_tgt_devsel        = 2'($urandom);
            cfg_tgt_addr          = ADDR_W'($urandom);
            cfg_tgt_wdata         = $urandom;
            cfg_tgt_expand_enable = 1'($urandom);
            cfg_tgt_expand_dir    = 1'($urandom);
            n++;
        end
        if (done_cnt == from) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL done_timeout actual=no_done required=done within 100 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run_op(input logic [1:0] dev, input logic [ADDR_W-1:0] addr,
                          input logic wr, input logic rd, input logic ex, input logic dir,
                          input logic [31:0] wdata, input int unsigned hold);
        int unsigned s;
        @(negedge clock_afu);
        push_exp(dev, addr, wr, rd, ex, wdata, cyc);
        cfg_tgt_devsel        = dev;
        cfg_tgt_addr          = addr;
        cfg_tgt_wren          = wr;
        cfg_tgt_rden          = rd;
        cfg_tgt_wdata         = wdata;
        cfg_tgt_expand_enable = ex;
        cfg_tgt_expand_dir    = dir;
        s = done_cnt;
        wait_done(s);
        repeat (hold) @(negedge clock_afu);
        cfg_tgt_wren = 1'b0;
        cfg_tgt_rden = 1'b0;
        @(negedge clock_afu);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},   32'(tgt_cfg_done), 32'd0);
        check({tag, "_rdata"},  tgt_cfg_rdata, 32'd0);
        check({tag, "_bresp"},  32'(tgt_cfg_bresp), 32'd0);
        check({tag, "_rresp"},  32'(tgt_cfg_rresp), 32'd0);
        check({tag, "_status"}, 32'(tgt_cfg_status), 32'd0);
        check({tag, "_err"},    32'(tgt_err_unimplemented_addr), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expectation; responses stay quiet otherwise.
    always @(posedge clock_afu) begin
        #1;
        if (tgt_cfg_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (sb.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("rdata",  tgt_cfg_rdata, mon_e.rdata);
                check("bresp",  32'(tgt_cfg_bresp), 32'(mon_e.bresp));
                check("rresp",  32'(tgt_cfg_rresp), 32'(mon_e.rresp));
                check("err",    32'(tgt_err_unimplemented_addr), 32'(mon_e.err));
                check("status", 32'(tgt_cfg_status), 32'(mon_e.status));
            end
        end else begin
            check("quiet_outputs",
                  32'({tgt_err_unimplemented_addr, tgt_cfg_bresp, tgt_cfg_rresp}), 32'd0);
        end
    end

    initial begin
        reset_afu             = 1'b1;
        cfg_tgt_devsel        = '0;
        cfg_tgt_addr          = '0;
        cfg_tgt_wren          = 1'b0;
        cfg_tgt_wdata         = '0;
        cfg_tgt_rden          = 1'b0;
        cfg_tgt_expand_enable = 1'b0;
        cfg_tgt_expand_dir    = 1'b0;
        repeat (3) @(negedge clock_afu);
        check_reset_outputs("reset");
        reset_afu = 1'b0;

        // Fill every valid word so later reads have known contents.
        for (int d = 0; d < NUM_DEV; d++) begin
            for (int a = 0; a < DEPTH; a++) begin
                run_op(2'(d), ADDR_W'(a), 1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom, 0);
            end
        end

        // Directed cases.
        run_op(2'd0, ADDR_W'(5), 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_1234, 0);
        run_op(2'd0, ADDR_W'(5), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1);
        run_op(2'd1, ADDR_W'(9), 1'b1, 1'b0, 1'b1, 1'b1, 32'h1122_3344, 0);
        run_op(2'd1, ADDR_W'(9), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        run_op(2'd1, ADDR_W'(9), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        run_op(2'd1, ADDR_W'(9), 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 0);
        run_op(2'd3, ADDR_W'(5), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        run_op(2'd0, ADDR_W'(DEPTH), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        run_op(2'd1, ADDR_W'(16383), 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 0);
        run_op(2'd0, ADDR_W'(5), 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 3);
        run_op(2'd0, ADDR_W'(5), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);

        // Reset mid-BUSY with the request dropped: write must be abandoned.
        @(negedge clock_afu);
        cfg_tgt_devsel        = 2'd0;
        cfg_tgt_addr          = ADDR_W'(7);
        cfg_tgt_wdata         = 32'h0BAD_F00D;
        cfg_tgt_expand_enable = 1'b0;
        cfg_tgt_wren          = 1'b1;
        @(negedge clock_afu);
        reset_afu = 1'b1;
        #1;
        sb.delete();
        model_status = 8'd0;
        check_reset_outputs("midbusy_reset");
        cfg_tgt_wren = 1'b0;
        @(negedge clock_afu);
        reset_afu = 1'b0;
        run_op(2'd0, ADDR_W'(7), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);

        // Reset mid-BUSY with the request still held: it runs again as a new request.
        @(negedge clock_afu);
        cfg_tgt_devsel        = 2'd0;
        cfg_tgt_addr          = ADDR_W'(8);
        cfg_tgt_wdata         = 32'h5A5A_C3C3;
        cfg_tgt_expand_enable = 1'b0;
        cfg_tgt_wren          = 1'b1;
        @(negedge clock_afu);
        reset_afu = 1'b1;
        sb.delete();
        model_status = 8'd0;
        @(negedge clock_afu);
        reset_afu = 1'b0;
        push_exp(2'd0, ADDR_W'(8), 1'b1, 1'b0, 1'b0, 32'h5A5A_C3C3, cyc);
        start = done_cnt;
        wait_done(start);
        cfg_tgt_wren = 1'b0;
        @(negedge clock_afu);
        run_op(2'd0, ADDR_W'(8), 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 0);

        // Random traffic; more than 256 completions so status wraps.
        for (int i = 0; i < 300; i++) begin
            r_dev  = ($urandom_range(0, 99) < 8) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 99) < 8) ? ADDR_W'($urandom_range(DEPTH, 16383))
                                                 : ADDR_W'($urandom_range(0, DEPTH - 1));
            r_op   = $urandom_range(0, 9);
            r_wr   = (r_op <= 4);
            r_rd   = (r_op == 0) || (r_op > 4);
            if (r_op == 0) begin
                r_dev  = 2'($urandom_range(0, 1));
                r_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            run_op(r_dev, r_addr, r_wr, r_rd, 1'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, 2));
        end

        repeat (5) @(negedge clock_afu);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_target_model.md
CFG_TARGET_MODEL -- requirements
Module: cfg_target_model

Interface
REQ-001 SHALL have parameter NUM_DEV, default 2, number of targets modelled (1..4).
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit words per target (power of 2, 16..4096).
REQ-003 SHALL have parameter LAT, default 2, cycles from request accept to done, per beat (1..15).
REQ-004 SHALL have parameter ADDR_W, default 14, width of the request address.
REQ-005 SHALL have port clock_afu, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_afu, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cfg_tgt_devsel, input, 2, target select.
REQ-008 SHALL have port cfg_tgt_addr, input, ADDR_W, word address.
REQ-009 SHALL have port cfg_tgt_wren, input, 1, write request, held until done.
REQ-010 SHALL have port cfg_tgt_wdata, input, 32, write data, valid while wren=1.
REQ-011 SHALL have port cfg_tgt_rden, input, 1, read request, held until done.
REQ-012 SHALL have port cfg_tgt_expand_enable, input, 1, 1 = execute as four byte beats.
REQ-013 SHALL have port cfg_tgt_expand_dir, input, 1, beat order: 0 = bytes 0,1,2,3; 1 = bytes 3,2,1,0.
REQ-014 SHALL have port tgt_cfg_rdata, output, 32, read data, valid with done on reads.
REQ-015 SHALL have port tgt_cfg_done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port tgt_cfg_bresp, output, 2, write response (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-017 SHALL have port tgt_cfg_rresp, output, 2, read response, same encoding as bresp.
REQ-018 SHALL have port tgt_cfg_status, output, 8, count of completed operations, modulo 256.
REQ-019 SHALL have port tgt_err_unimplemented_addr, output, 1, one-cycle pulse on an out-of-range access.

Function
REQ-020 SHALL implement a state machine with states IDLE, BUSY, DONE and WAIT_DROP.
REQ-021 SHALL, in IDLE, on wren=1 or rden=1:
- latch devsel, addr, wdata, op, expand_enable and expand_dir;
- go to BUSY with the latency counter set to LAT-1.
REQ-022 SHALL, in BUSY, decrement the counter each cycle; at 0:
- non-expand access: go to DONE;
- expand access: advance to the next beat and reload the counter; go to DONE after beat 3.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE, with rdata and bresp/rresp valid in that cycle, then go to WAIT_DROP.
REQ-024 SHALL stay in WAIT_DROP until wren=0 and rden=0, then return to IDLE; no new request is accepted in WAIT_DROP.
REQ-025 SHALL place done LAT+1 cycles after the request is first seen in IDLE for a non-expand access, and 4*LAT+1 cycles for an expand access.
REQ-026 SHALL perform a write, for a valid access, in the DONE cycle:
- non-expand: full word;
- expand: one byte lane per beat, in beat order.
Final memory contents are identical in both modes.
REQ-027 SHALL return the stored word on a valid read; an expand read assembles the bytes in beat order into their own lanes.
REQ-028 SHALL treat devsel >= NUM_DEV as DECERR:
- resp = 11, rdata = 0, no write, no error pulse.
REQ-029 SHALL treat addr >= DEPTH (with devsel valid) as SLVERR:
- resp = 10, rdata = 0, no write;
- tgt_err_unimplemented_addr pulses with done.
REQ-030 SHALL treat wren=1 and rden=1 together in IDLE as SLVERR on both bresp and rresp: rdata = 0, no write.
REQ-031 SHALL drive bresp = 00 during reads and rresp = 00 during writes; both are 00 outside DONE.
REQ-032 SHALL increment tgt_cfg_status once per done pulse, wrapping 255 -> 0, errors included.
REQ-033 SHALL keep request input changes during BUSY/DONE from affecting the operation in flight.

Reset
REQ-034 SHALL, on reset_afu=1, immediately force:
- state IDLE;
- done = 0, rdata = 0, bresp = rresp = 00, status = 0, error pulse = 0.
REQ-035 SHALL abandon any operation in flight on reset with no partial write beyond beats already committed; memory contents are not cleared.
REQ-036 SHALL, after reset deassertion with wren or rden still high, treat the request as new.

Verification
REQ-037 SHALL cover: LAT=2, write dev0 addr 5 = 32'hA5A5_1234, then read -> done 3 cycles after each request, rdata = 32'hA5A5_1234, resp 00.
REQ-038 SHALL cover: expand write 32'h1122_3344 with dir=1, then non-expand read -> done 4*LAT+1 cycles after the request, rdata = 32'h1122_3344.
REQ-039 SHALL cover: NUM_DEV=2, devsel=3 read -> rresp 11, rdata 0, no error pulse; addr=DEPTH -> rresp 10, error pulse with done.
REQ-040 SHALL cover: wren and rden together -> bresp = rresp = 10, memory unchanged; holding the request after done -> no second done.
REQ-041 SHALL cover: reset asserted mid-BUSY -> outputs zero immediately, status 0, no done; 256 operations -> status wraps to 0.
